imem_boot_ctrl: RTL

Sequences the instruction memory's life cycle. After reset it clears every word to the fill instruction, then accepts a program from a host over a valid/ready word stream and writes it sequentially from address 0. It then releases the pipeline and hands the memory address port to the fetch-stage PC. The block sits between the host loader, the fetch-stage PC, the instruction memory write port and the pipeline reset/stall controls.

---
 rtl/imem_boot_ctrl_pkg.sv | 9 +
 rtl/imem_load_counter.sv | 26 ++
 rtl/imem_boot_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_ctrl_pkg;

   typedef enum logic [1:0] {CLEAR, LOAD, RELEASE, RUN} imem_ctrl_state_t;

   // ADDI x0,x0,0: every unloaded word executes as a NOP
   localparam logic [31:0] IMEM_FILL_WORD = 32'h0000_0013;

endpackage

// File: rtl/imem_load_counter.sv
// Word-index counter for the boot controller: clear, increment and last-word flag.
// One extra bit beyond the address width so a full load reads back as WordQuantity.
module imem_load_counter #(
   parameter int WordQuantity = 256,
   parameter int BitSize      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               inc,
   output logic [BitSize:0]   idx,
   output logic               tc
);

   localparam logic [BitSize:0] LAST = (BitSize+1)'(WordQuantity-1);

   always_ff @(posedge clk) begin
      if (rst || clr)
         idx <= '0;
      else if (inc)
         idx <= idx + (BitSize+1)'(1);
   end

   assign tc = (idx == LAST);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory life cycle: clear to NOP, stream in a program, release the core.
// Optional running checksum of loaded words when IMEM_LOAD_SUM_EN is defined.
module imem_boot_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int WordQuantity = 256,
   parameter int BitSize      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        fetch_addr,
   input  logic               load_valid,
   input  logic [31:0]        load_data,
   input  logic               load_last,
   output logic               load_ready,
   input  logic               reload_req,
   output logic [31:0]        mem_addr,
   output logic [31:0]        mem_wdata,
   output logic               mem_we,
   output logic               core_rst,
   output logic               core_stall,
   output logic [BitSize:0]   words_loaded,
   output logic               load_overflow,
   output logic [31:0]        load_sum
);

   imem_ctrl_state_t state, state_nxt;
   logic [BitSize:0] idx;
   logic             tc;
   logic             hs;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             load_end;
   logic             reload_go;
   logic [31:0]      idx_addr;

   imem_load_counter #(
      .WordQuantity (WordQuantity),
      .BitSize      (BitSize)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .idx (idx),
      .tc  (tc)
   );

   assign hs        = load_valid && (state == LOAD);
   assign reload_go = reload_req && (state == RUN);
   assign idx_addr  = {{(30-BitSize){1'b0}}, idx[BitSize-1:0], 2'b00};

   always_ff @(posedge clk) begin
      if (rst)
         state <= CLEAR;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      load_end   = 1'b0;
      load_ready = 1'b0;
      mem_we     = 1'b0;
      mem_wdata  = load_data;
      mem_addr   = fetch_addr;
      core_rst   = 1'b0;
      core_stall = 1'b0;
      case (state)
         CLEAR: begin
            mem_we     = 1'b1;
            mem_wdata  = IMEM_FILL_WORD;
            mem_addr   = idx_addr;
            core_rst   = 1'b1;
            core_stall = 1'b1;
            if (tc) begin
               cnt_clr   = 1'b1;
               state_nxt = LOAD;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         LOAD: begin
            load_ready = 1'b1;
            mem_we     = load_valid;
            mem_addr   = idx_addr;
            core_rst   = 1'b1;
            core_stall = 1'b1;
            if (hs) begin
               cnt_inc = 1'b1;
               // capacity end and load_last both terminate; words_loaded captures idx+1
               if (load_last || tc) begin
                  load_end  = 1'b1;
                  state_nxt = RELEASE;
               end
            end
         end
         RELEASE: begin
            core_stall = 1'b1;
            state_nxt  = RUN;
         end
         RUN: begin
            if (reload_go) begin
               cnt_clr   = 1'b1;
               state_nxt = CLEAR;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         words_loaded <= '0;
      else if (load_end)
         words_loaded <= idx + (BitSize+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst || reload_go)
         load_overflow <= 1'b0;
      else if (load_end && tc && !load_last)
         load_overflow <= 1'b1;
   end

`ifdef IMEM_LOAD_SUM_EN
   always_ff @(posedge clk) begin
      if (rst || reload_go)
         load_sum <= '0;
      else if (hs)
         load_sum <= load_sum + load_data;
   end
`else
   assign load_sum = 32'h0000_0000;
`endif

endmodule
